mem_port_arbiter: RTL and testbench

- Single-port controller that shares the unified byte-addressed instruction/data memory between two requesters: the instruction-fetch stage (I) and the load/store stage (D).
- Sequences every access into the memory's one-cycle synchronous read timing.
- Checks mode legality and address range before any access.
- Returns read data and completion/error status to the owning requester through a req/ack handshake.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port arbiter sharing one byte-addressed memory between the
// instruction-fetch requester (I) and the load/store requester (D).
// Every access runs IDLE -> ACCESS -> RESP against the memory's
// one-cycle synchronous read; illegal accesses skip ACCESS.
//
// Handshake: a requester raises req with its fields stable and holds them
// until its one-cycle ack pulse; err and rdata are valid only during ack.
// A req still high in IDLE after an ack is treated as a new request.
module mem_port_arbiter #(
    parameter int MEM_BYTES    = 4096,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_mode,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_mode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ACCESS = 2'd1;
    localparam logic [1:0]  S_RESP   = 2'd2;
    localparam logic        OWN_I    = 1'b0;
    localparam logic        OWN_D    = 1'b1;
    localparam logic [3:0]  RUN_MAX  = 4'(MAX_DATA_RUN);
    localparam logic [32:0] MEM_TOP  = 33'(MEM_BYTES);

    logic [1:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic [3:0]  run_cnt_q, run_cnt_d;
    logic        err_flag_q, err_flag_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [2:0]  mem_mode_q, mem_mode_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        grant_d, grant_i;
    logic        sel_we;
    logic [2:0]  sel_mode;
    logic [31:0] sel_addr, sel_wdata;
    logic [32:0] sel_size;
    logic        sel_illegal;

    // Bytes touched by a mode; illegal modes are rejected separately.
    function automatic logic [32:0] access_size(input logic [2:0] mode);
        case (mode)
            3'b000:         access_size = 33'd4;
            3'b001, 3'b011: access_size = 33'd2;
            default:        access_size = 33'd1;
        endcase
    endfunction

    // Arbitration and legality of the candidate access seen in IDLE.
    always_comb begin
        grant_d     = d_req && !(i_req && (run_cnt_q == RUN_MAX));
        grant_i     = i_req && !grant_d;
        sel_we      = grant_d && d_we;
        sel_mode    = grant_d ? d_mode  : 3'b000;
        sel_addr    = grant_d ? d_addr  : i_addr;
        sel_wdata   = grant_d ? d_wdata : 32'h0;
        sel_size    = access_size(sel_mode);
        // 33-bit compare so addresses near 2^32 cannot wrap into range.
        sel_illegal = (sel_mode > 3'b100)
                   || (sel_we && ((sel_mode == 3'b011) || (sel_mode == 3'b100)))
                   || ({1'b0, sel_addr} > (MEM_TOP - sel_size));
    end

    // Next-state logic for the access sequencer and fairness counter.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        run_cnt_d   = run_cnt_q;
        err_flag_d  = err_flag_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_mode_d  = mem_mode_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (!i_req) begin
                    run_cnt_d = 4'd0;
                end
                if (grant_d || grant_i) begin
                    owner_d     = grant_d ? OWN_D : OWN_I;
                    mem_mode_d  = sel_mode;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    if (grant_i) begin
                        run_cnt_d = 4'd0;
                    end else if (i_req && (run_cnt_q != RUN_MAX)) begin
                        run_cnt_d = run_cnt_q + 4'd1;
                    end
                    if (sel_illegal) begin
                        err_flag_d  = 1'b1;
                        mem_read_d  = 1'b0;
                        mem_write_d = 1'b0;
                        state_d     = S_RESP;
                    end else begin
                        mem_read_d  = !sel_we;
                        mem_write_d = sel_we;
                        state_d     = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // Memory acts on the edge closing this cycle; address held in RESP.
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                err_flag_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                err_flag_d  = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_I;
            run_cnt_q   <= 4'd0;
            err_flag_q  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_mode_q  <= 3'b000;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            run_cnt_q   <= run_cnt_d;
            err_flag_q  <= err_flag_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_mode_q  <= mem_mode_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Response decode from registered state; rdata passes mem_rdata during ack.
    always_comb begin
        mem_read  = mem_read_q;
        mem_write = mem_write_q;
        mem_mode  = mem_mode_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        busy      = (state_q != S_IDLE);
        i_ack     = (state_q == S_RESP) && (owner_q == OWN_I);
        d_ack     = (state_q == S_RESP) && (owner_q == OWN_D);
        i_err     = i_ack && err_flag_q;
        d_err     = d_ack && err_flag_q;
        i_rdata   = i_ack ? mem_rdata : 32'h0;
        d_rdata   = d_ack ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-addressed memory model with registered
// data_out and load extension, table-driven D accesses, and hand-written
// sequences for fetch, contention, starvation and mid-access reset.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_mode = 3'b000;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:4095];
  logic [0:0]  exp_q[$];

  typedef struct {
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [18];

  mem_port_arbiter #(.MEM_BYTES(4096), .MAX_DATA_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_mode(d_mode), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_mode(mem_mode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  // memory model: writes and data_out update on the rising edge
  always @(posedge clk) begin
    int a;
    a = int'(mem_addr[11:0]);
    if (mem_write) begin
      case (mem_mode)
        3'b000: begin
          mem[a] <= mem_wdata[7:0];     mem[a+1] <= mem_wdata[15:8];
          mem[a+2] <= mem_wdata[23:16]; mem[a+3] <= mem_wdata[31:24];
        end
        3'b001: begin mem[a] <= mem_wdata[7:0]; mem[a+1] <= mem_wdata[15:8]; end
        default: mem[a] <= mem_wdata[7:0];
      endcase
    end
    if (mem_read) begin
      case (mem_mode)
        3'b000:  mem_rdata <= {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        3'b001:  mem_rdata <= {16'h0, mem[a+1], mem[a]};
        3'b011:  mem_rdata <= {{16{mem[a+1][7]}}, mem[a+1], mem[a]};
        3'b010:  mem_rdata <= {24'h0, mem[a]};
        default: mem_rdata <= {{24{mem[a][7]}}, mem[a]};
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // wait at a negedge until the DUT is idle so the next edge samples
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // D request already driven; count cycles from the sampling edge to d_ack
  task automatic wait_d(input int exp_lat, input logic exp_err, input logic chk_rd,
                        input logic [31:0] exp_rd, input int exp_w, input int exp_r,
                        input string nm);
    int cyc = 0, nw = 0, nr = 0;
    bit got = 0, iack = 0;
    logic err = 1'b0;
    logic [31:0] rd = 32'h0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_write) nw++;
      if (mem_read) nr++;
      if (i_ack) iack = 1;
      if (d_ack) begin
        got = 1; err = d_err; rd = d_rdata;
      end
    end
    d_req = 1'b0;
    chk({nm, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      chk({nm, "_lat"}, cyc, exp_lat);
      chk({nm, "_err"}, 32'(err), 32'(exp_err));
      if (chk_rd) chk({nm, "_rdata"}, rd, exp_rd);
      chk({nm, "_writes"}, nw, exp_w);
      chk({nm, "_reads"}, nr, exp_r);
    end
    chk({nm, "_no_iack"}, 32'(iack), 32'd0);
  endtask

  task automatic run_d(input vec_t v, input string nm);
    bit ok;
    ok = !v.exp_err;
    wait_idle();
    d_we = v.we; d_mode = v.mode; d_addr = v.addr; d_wdata = v.wdata;
    d_req = 1'b1;
    wait_d(ok ? 2 : 1, v.exp_err, ok && !v.we, v.exp_rdata,
           (ok && v.we) ? 1 : 0, (ok && !v.we) ? 1 : 0, nm);
  endtask

  task automatic run_i(input logic [31:0] addr, input logic exp_err,
                       input logic [31:0] exp_rd, input string nm);
    int cyc = 0, nr = 0, rd_cyc = 0;
    bit got = 0, dack = 0;
    logic err = 1'b0;
    logic [31:0] rd = 32'h0;
    wait_idle();
    i_addr = addr;
    i_req = 1'b1;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_read) begin nr++; rd_cyc = cyc; end
      if (d_ack) dack = 1;
      if (i_ack) begin got = 1; err = i_err; rd = i_rdata; end
    end
    i_req = 1'b0;
    chk({nm, "_ack"}, 32'(got), 32'd1);
    chk({nm, "_lat"}, cyc, exp_err ? 1 : 2);
    chk({nm, "_err"}, 32'(err), 32'(exp_err));
    if (!exp_err) begin
      chk({nm, "_rdata"}, rd, exp_rd);
      chk({nm, "_read_cycle"}, rd_cyc, 1);
    end
    chk({nm, "_reads"}, nr, exp_err ? 0 : 1);
    chk({nm, "_no_dack"}, 32'(dack), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
    mem[16'h10] = 8'h33; mem[16'h11] = 8'h22; mem[16'h12] = 8'h11; mem[16'h13] = 8'h00;

    vecs[0]  = '{1'b1, 3'b000, 32'h040, 32'h12345678, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 32'h040, 32'h0,        1'b0, 32'h12345678};
    vecs[2]  = '{1'b1, 3'b010, 32'h100, 32'hAABBCCDD, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'b100, 32'h100, 32'h0,        1'b0, 32'hFFFFFFDD};
    vecs[4]  = '{1'b0, 3'b010, 32'h100, 32'h0,        1'b0, 32'h000000DD};
    vecs[5]  = '{1'b1, 3'b001, 32'h200, 32'hBEEF8001, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 3'b011, 32'h200, 32'h0,        1'b0, 32'hFFFF8001};
    vecs[7]  = '{1'b0, 3'b001, 32'h200, 32'h0,        1'b0, 32'h00008001};
    vecs[8]  = '{1'b1, 3'b011, 32'h200, 32'h11112222, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 3'b100, 32'h200, 32'h11112222, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 3'b000, 32'hFFE, 32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b0, 3'b010, 32'hFFF, 32'h0,        1'b0, 32'h000000FF};
    vecs[12] = '{1'b0, 3'b001, 32'hFFE, 32'h0,        1'b0, 32'h0000FFFE};
    vecs[13] = '{1'b0, 3'b001, 32'hFFF, 32'h0,        1'b1, 32'h0};
    vecs[14] = '{1'b0, 3'b101, 32'h000, 32'h0,        1'b1, 32'h0};
    vecs[15] = '{1'b0, 3'b000, 32'hFFC, 32'h0,        1'b0, 32'hFFFEFDFC};
    vecs[16] = '{1'b0, 3'b000, 32'hFFFFFFFF, 32'h0,   1'b1, 32'h0};
    vecs[17] = '{1'b1, 3'b111, 32'h000, 32'h5,        1'b1, 32'h0};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_mode", 32'(mem_mode), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_acks", {28'h0, i_ack, d_ack, i_err, d_err}, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // fetch only
    run_i(32'h10, 1'b0, 32'h00112233, "fetch");
    run_i(32'hFFD, 1'b1, 32'h0, "fetch_oob");

    // table-driven D accesses
    for (int k = 0; k < 18; k++) run_d(vecs[k], $sformatf("vec%0d", k));
    chk("st_byte_100", 32'(mem[16'h100]), 32'hDD);
    chk("st_byte_101", 32'(mem[16'h101]), 32'h01);

    // concurrent I and D: D first (cycle 2), I next (cycle 5)
    begin
      int cyc = 0, dcyc = 0, icyc = 0;
      bit anyw = 0;
      logic [31:0] drd = 32'h0, ird = 32'h0;
      wait_idle();
      d_we = 1'b0; d_mode = 3'b000; d_addr = 32'h20; i_addr = 32'h10;
      d_req = 1'b1; i_req = 1'b1;
      while ((dcyc == 0 || icyc == 0) && cyc < 15) begin
        @(posedge clk); #1;
        cyc++;
        if (mem_write) anyw = 1;
        if (d_ack) begin dcyc = cyc; drd = d_rdata; d_req = 1'b0; end
        if (i_ack) begin icyc = cyc; ird = i_rdata; i_req = 1'b0; end
      end
      d_req = 1'b0; i_req = 1'b0;
      chk("conc_d_cycle", dcyc, 2);
      chk("conc_i_cycle", icyc, 5);
      chk("conc_d_rdata", drd, 32'h23222120);
      chk("conc_i_rdata", ird, 32'h00112233);
      chk("conc_no_write", 32'(anyw), 32'd0);
    end

    // starvation: 4 D grants then I
    begin
      int cyc = 0, nd = 0;
      bit done = 0;
      logic [0:0] e;
      for (int k = 0; k < 4; k++) exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      wait_idle();
      d_we = 1'b0; d_mode = 3'b000; d_addr = 32'h30; i_addr = 32'h10;
      d_req = 1'b1; i_req = 1'b1;
      while (!done && cyc < 60) begin
        @(posedge clk); #1;
        cyc++;
        if (d_ack || i_ack) begin
          if (exp_q.size() == 0) begin
            chk("starve_q_empty", 32'd1, 32'd0);
            done = 1;
          end else begin
            e = exp_q.pop_front();
            chk("starve_owner", 32'(d_ack), 32'(e));
            if (d_ack) begin
              nd++;
              chk("starve_d_rdata", d_rdata, 32'h33323130);
            end
            if (i_ack) begin
              chk("starve_i_rdata", i_rdata, 32'h00112233);
              chk("starve_run_cnt", 32'(dut.run_cnt_q), 32'd0);
              done = 1;
            end
          end
        end
      end
      d_req = 1'b0; i_req = 1'b0;
      chk("starve_done", 32'(done), 32'd1);
      chk("starve_d_count", nd, 4);
      chk("starve_q_left", exp_q.size(), 0);
    end

    // reset during ACCESS of a D store, then re-served after release
    begin
      wait_idle();
      d_we = 1'b1; d_mode = 3'b000; d_addr = 32'h300; d_wdata = 32'hCAFEF00D;
      d_req = 1'b1;
      @(posedge clk); #1;
      chk("rstacc_write_hi", 32'(mem_write), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstacc_strobes", {30'h0, mem_read, mem_write}, 32'd0);
      chk("rstacc_mode", 32'(mem_mode), 32'd0);
      chk("rstacc_addr", mem_addr, 32'd0);
      chk("rstacc_wdata", mem_wdata, 32'd0);
      chk("rstacc_ack", 32'(d_ack), 32'd0);
      chk("rstacc_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_d(2, 1'b0, 1'b0, 32'h0, 1, 0, "rstacc_reserve");
      run_d('{1'b0, 3'b000, 32'h300, 32'h0, 1'b0, 32'hCAFEF00D}, "rstacc_readback");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // absolute time limit
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
